systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder.sv | 204 ++++++++++++++++++++
 tb/tb_systolic_feeder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder
// Buffers 8-bit row words from a host in a small FIFO and drives them into
// row 0 of a systolic array. Each array advance strobe (step) pops one word
// (or a bubble when the FIFO is empty) into a head register.
//
// Build option: define FEEDER_SKEW_EN to add the per-lane skew pipeline, in
// which lane j lags the head by j additional steps. With the macro undefined
// the head register drives every lane directly (one-step latency on all lanes).
module systolic_feeder #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       step,
    output logic [7:0] out_data,
    output logic [7:0] out_valid,
    output logic       busy,
    output logic [7:0] word_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Pointers wrap by natural overflow, which needs a power-of-two depth.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("systolic_feeder: DEPTH must be a power of two and at least 2");
    end

    // ------------------------------------------------------------------
    // FIFO storage and control state
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [7:0]       head_q;
    logic [7:0]       head_d;
    logic             head_valid_q;
    logic             head_valid_d;
    logic [7:0]       word_count_q;
    logic [7:0]       word_count_d;

    logic             full_s;
    logic             empty_s;
    logic             in_ready_s;
    logic             push_s;
    logic             pop_s;

    // Handshake decode: full blocks in_ready even if a pop happens this cycle.
    always_comb begin
        full_s     = (count_q == DEPTH_C);
        empty_s    = (count_q == {CNT_W{1'b0}});
        in_ready_s = !full_s && !reset;
        push_s     = in_valid && in_ready_s;
        pop_s      = step && !empty_s;
    end

    // Pointer, occupancy and accepted-word counter next-state.
    always_comb begin
        if (push_s) begin
            wr_ptr_d     = wr_ptr_q + PTR_W'(1);
            word_count_d = word_count_q + 8'd1;
        end else begin
            wr_ptr_d     = wr_ptr_q;
            word_count_d = word_count_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Head next-state: a step pops the oldest word, or loads a bubble when
    // the FIFO was empty before this edge (no same-cycle bypass of a push).
    always_comb begin
        if (step) begin
            if (pop_s) begin
                head_d       = mem_q[rd_ptr_q];
                head_valid_d = 1'b1;
            end else begin
                head_d       = 8'h00;
                head_valid_d = 1'b0;
            end
        end else begin
            head_d       = head_q;
            head_valid_d = head_valid_q;
        end
    end

    // FIFO word storage; cleared on reset so no stale data is ever visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Control, head and word counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            head_q       <= 8'h00;
            head_valid_q <= 1'b0;
            word_count_q <= 8'h00;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
            word_count_q <= word_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Lane output stage
    // ------------------------------------------------------------------
`ifdef FEEDER_SKEW_EN
    wire [7:0] lane_dat_s;
    wire [7:0] lane_vld_s;

    // Lane 0 is taken straight from the head register.
    assign lane_dat_s[0] = head_q[0];
    assign lane_vld_s[0] = head_valid_q;

    // Lane j carries a j-deep shift register that advances only on step.
    for (genvar j = 1; j < 8; j++) begin : g_lane
        logic [j-1:0] dly_dat_q;
        logic [j-1:0] dly_dat_d;
        logic [j-1:0] dly_vld_q;
        logic [j-1:0] dly_vld_d;

        if (j == 1) begin : g_single
            // One-stage lane: capture the head bit on each step.
            always_comb begin
                if (step) begin
                    dly_dat_d = head_q[1];
                    dly_vld_d = head_valid_q;
                end else begin
                    dly_dat_d = dly_dat_q;
                    dly_vld_d = dly_vld_q;
                end
            end
        end else begin : g_chain
            // Multi-stage lane: shift the head bit in at the low end.
            always_comb begin
                if (step) begin
                    dly_dat_d = {dly_dat_q[j-2:0], head_q[j]};
                    dly_vld_d = {dly_vld_q[j-2:0], head_valid_q};
                end else begin
                    dly_dat_d = dly_dat_q;
                    dly_vld_d = dly_vld_q;
                end
            end
        end

        // Skew registers; reset drops every in-flight bit.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dly_dat_q <= {j{1'b0}};
                dly_vld_q <= {j{1'b0}};
            end else begin
                dly_dat_q <= dly_dat_d;
                dly_vld_q <= dly_vld_d;
            end
        end

        assign lane_dat_s[j] = dly_dat_q[j-1];
        assign lane_vld_s[j] = dly_vld_q[j-1];
    end

    assign out_data  = lane_dat_s;
    assign out_valid = lane_vld_s;
`else
    // Unskewed build: every lane sees the head register directly.
    assign out_data  = head_q;
    assign out_valid = {8{head_valid_q}};
`endif

    assign in_ready   = in_ready_s;
    assign busy       = !empty_s || (|out_valid);
    assign word_count = word_count_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder
// Randomised and directed stimulus against a queue-based reference model.
// The model keeps the FIFO as a queue, plus the history of head values of
// the last eight steps; lane j's expected output is the head from j steps ago.
module tb_systolic_feeder;

    localparam int DEPTH = 4;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] in_data  = 8'h00;
    logic       in_valid = 1'b0;
    logic       step     = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic [7:0] out_valid;
    logic       busy;
    logic [7:0] word_count;

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic [7:0] hd[8];
    logic       hv[8];
    logic [7:0] m_wc = 8'h00;

    systolic_feeder #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .step       (step),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .busy       (busy),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs present at it.
    task automatic model_step();
        bit do_push;
        bit do_pop;
        if (reset) begin
            mq.delete();
            for (int k = 0; k < 8; k++) begin
                hd[k] = 8'h00;
                hv[k] = 1'b0;
            end
            m_wc = 8'h00;
        end else begin
            do_push = in_valid && (mq.size() < DEPTH);
            do_pop  = step && (mq.size() > 0);
            if (step) begin
                for (int k = 7; k > 0; k--) begin
                    hd[k] = hd[k-1];
                    hv[k] = hv[k-1];
                end
                if (do_pop) begin
                    hd[0] = mq.pop_front();
                    hv[0] = 1'b1;
                end else begin
                    hd[0] = 8'h00;
                    hv[0] = 1'b0;
                end
            end
            if (do_push) begin
                mq.push_back(in_data);
                m_wc = m_wc + 8'd1;
            end
        end
    endtask

    function automatic logic [7:0] exp_data();
        logic [7:0] r;
`ifdef FEEDER_SKEW_EN
        for (int j = 0; j < 8; j++) r[j] = hd[j][j];
`else
        r = hd[0];
`endif
        return r;
    endfunction

    function automatic logic [7:0] exp_valid();
        logic [7:0] r;
`ifdef FEEDER_SKEW_EN
        for (int j = 0; j < 8; j++) r[j] = hv[j];
`else
        r = {8{hv[0]}};
`endif
        return r;
    endfunction

    // Compare process: model updates at the rising edge, DUT checked at the falling edge.
    initial begin
        logic       e_rdy;
        logic       e_busy;
        logic [7:0] e_dat;
        logic [7:0] e_vld;
        for (int k = 0; k < 8; k++) begin
            hd[k] = 8'h00;
            hv[k] = 1'b0;
        end
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            e_dat  = exp_data();
            e_vld  = exp_valid();
            e_rdy  = !reset && (mq.size() < DEPTH);
            e_busy = (mq.size() > 0) || (|e_vld);
            chk("model_in_ready",   in_ready,   e_rdy);
            chk("model_out_data",   out_data,   e_dat);
            chk("model_out_valid",  out_valid,  e_vld);
            chk("model_busy",       busy,       e_busy);
            chk("model_word_count", word_count, m_wc);
        end
    end

    // Apply one cycle of inputs; returns just after the following falling edge.
    task automatic cyc(input logic v, input logic [7:0] d, input logic s);
        in_valid = v;
        in_data  = d;
        step     = s;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
    endtask

    // Directed scenarios followed by a randomised soak.
    initial begin
        logic [7:0] w;
        logic [7:0] ov_h[12];
        logic [7:0] od_h[12];
        logic       bz_h[12];
        logic [7:0] exp_seq[4];
        logic       v;
        logic       s;
        logic [7:0] d;
        int         first;
        int         cnt;
        int         jj;

        // Reset state
        reset = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("rst_out_data",   out_data,   8'h00);
        chk("rst_out_valid",  out_valid,  8'h00);
        chk("rst_busy",       busy,       1'b0);
        chk("rst_in_ready",   in_ready,   1'b0);
        chk("rst_word_count", word_count, 8'h00);
        reset = 1'b0;
        #1;
        chk("ready_after_release", in_ready, 1'b1);

        // Single word through an otherwise empty feeder, step held high
`ifdef FEEDER_SKEW_EN
        w = 8'hFF;
`else
        w = 8'h81;
`endif
        cyc(1'b1, w, 1'b1);
        for (int t = 0; t < 12; t++) begin
            cyc(1'b0, 8'h00, 1'b1);
            ov_h[t] = out_valid;
            od_h[t] = out_data;
            bz_h[t] = busy;
        end
`ifdef FEEDER_SKEW_EN
        for (int j = 0; j < 8; j++) begin
            first = -1;
            cnt   = 0;
            for (int t = 0; t < 12; t++) begin
                if (ov_h[t][j]) begin
                    cnt++;
                    if (first < 0) first = t;
                end
            end
            jj = j;
            chk("skew_lane_cycles", cnt[7:0], 8'd1);
            chk("skew_lane_offset", first[7:0], jj[7:0]);
            chk("skew_lane_data", od_h[j][j], 1'b1);
        end
        chk("busy_before_fall", bz_h[7], 1'b1);
        chk("busy_fall",        bz_h[8], 1'b0);
`else
        chk("noskew_data",       od_h[0], 8'h81);
        chk("noskew_valid",      ov_h[0], 8'hFF);
        chk("noskew_valid_next", ov_h[1], 8'h00);
        chk("noskew_busy_next",  bz_h[1], 1'b0);
`endif

        // Fill to full with step low; a fifth word is held off
        do_reset();
        cyc(1'b1, 8'h11, 1'b0);
        cyc(1'b1, 8'h22, 1'b0);
        cyc(1'b1, 8'h33, 1'b0);
        cyc(1'b1, 8'h44, 1'b0);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_count",    word_count, 8'd4);
        cyc(1'b1, 8'h55, 1'b0);
        cyc(1'b1, 8'h55, 1'b0);
        chk("held_count",    word_count, 8'd4);
        chk("held_in_ready", in_ready, 1'b0);

        // One step while full: pop 0x11, in_ready rises next cycle, 0x55 accepted
        cyc(1'b1, 8'h55, 1'b1);
        chk("pop_full_ready", in_ready, 1'b1);
        chk("pop_full_count", word_count, 8'd4);
`ifdef FEEDER_SKEW_EN
        chk("pop_full_lane0", out_data[0], 1'b1);
        chk("pop_full_vld0",  out_valid[0], 1'b1);
`else
        chk("pop_full_head",  out_data, 8'h11);
`endif
        cyc(1'b1, 8'h55, 1'b0);
        chk("refill_count", word_count, 8'd5);
        chk("refill_ready", in_ready, 1'b0);
        exp_seq[0] = 8'h22;
        exp_seq[1] = 8'h33;
        exp_seq[2] = 8'h44;
        exp_seq[3] = 8'h55;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
`ifdef FEEDER_SKEW_EN
            chk("order_lane0", out_data[0], exp_seq[i][0]);
            chk("order_vld0",  out_valid[0], 1'b1);
`else
            chk("order_word",  out_data, exp_seq[i]);
`endif
        end

        // Reset with words buffered and lanes in flight
        do_reset();
        cyc(1'b1, 8'hA1, 1'b0);
        cyc(1'b1, 8'hB2, 1'b0);
        cyc(1'b1, 8'hC3, 1'b0);
        cyc(1'b1, 8'hD4, 1'b1);
        cyc(1'b1, 8'hE5, 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst_out_data",  out_data,  8'h00);
        chk("midrst_out_valid", out_valid, 8'h00);
        chk("midrst_busy",      busy,      1'b0);
        chk("midrst_in_ready",  in_ready,  1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        cyc(1'b1, 8'h0F, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
`ifdef FEEDER_SKEW_EN
        chk("post_rst_data",  out_data,  8'h01);
        chk("post_rst_valid", out_valid, 8'h01);
        cyc(1'b0, 8'h00, 1'b1);
        chk("post_rst_data2",  out_data,  8'h02);
        chk("post_rst_valid2", out_valid, 8'h02);
`else
        chk("post_rst_data",  out_data,  8'h0F);
        chk("post_rst_valid", out_valid, 8'hFF);
        cyc(1'b0, 8'h00, 1'b1);
        chk("post_rst_valid2", out_valid, 8'h00);
`endif

        // Streaming 0xA5 with step high; word counter wraps
        do_reset();
        for (int i = 0; i < 256; i++) begin
            cyc(1'b1, 8'hA5, 1'b1);
            chk("stream_ready", in_ready, 1'b1);
            if (i >= 1) chk("stream_lane0", out_data[0], 1'b1);
            if (i >= 8) chk("stream_word", out_data, 8'hA5);
            if (i == 254) chk("stream_count_255", word_count, 8'hFF);
        end
        chk("stream_count_wrap", word_count, 8'h00);

        // Randomised soak alternating high and low step pressure
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            v = 1'($urandom_range(0, 1));
            d = 8'($urandom_range(0, 255));
            if (((i / 400) % 2) == 1) s = ($urandom_range(0, 3) == 0);
            else                      s = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 199) == 0);
            cyc(v, d, s);
        end
        reset = 1'b0;
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
